// File: rtl/obstacle_pkg.sv
// Shared definitions for the obstacle scheduler.
//   - FSM state encoding (2 bit): IDLE, GAP, LAUNCH, RUN
//   - COORD_W:    width of one obstacle coordinate
//   - N_OBST_DEF: default number of obstacle modules
//   - onehot8/wrap_inc: grant-vector and round-robin index helpers
//     (sized for up to 8 obstacles; callers truncate to N_OBST)
package obstacle_pkg;

  localparam int COORD_W    = 12;
  localparam int N_OBST_DEF = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GAP    = 2'd1;
  localparam logic [1:0] ST_LAUNCH = 2'd2;
  localparam logic [1:0] ST_RUN    = 2'd3;

  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    return 8'd1 << idx;
  endfunction

  // (idx + 1) mod n, for n in 2..8
  function automatic logic [2:0] wrap_inc(input logic [2:0] idx, input int n);
    if (int'(idx) >= n - 1) return 3'd0;
    return idx + 3'd1;
  endfunction

endpackage

// File: rtl/obstacle_lfsr.sv
// 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1 (maximal length).
// Used by obstacle_scheduler for random launch order.
// Ports:
//   clk   in  1  clock
//   rst_n in  1  asynchronous active-low reset (loads SEED)
//   en    in  1  advance one step
//   value out 8  current register contents
module obstacle_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [7:0] value
);

  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en) lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign value = lfsr_q;

endmodule

// File: rtl/obstacle_scheduler.sv
// Obstacle scheduler: waits a gap, launches one obstacle (done_control strobe
// plus one-hot selected), then waits for that obstacle's done pulse or a
// watchdog timeout. Muxes the active obstacle's coordinates to the collision
// checker. Any of menu_on / !play_selected / !game_on aborts to IDLE.
// Optional feature macro: OBSTACLE_SCHED_RANDOM_ORDER_EN
//   defined   - launch order from an 8-bit LFSR, never the same index twice in a row
//   undefined - round-robin launch order
// Ports:
//   pclk, rst_n        clock, asynchronous active-low reset
//   game_on, menu_on, play_selected   game-state qualifiers
//   obst_done[N]       per-obstacle 1-cycle done pulse
//   obst_working[N]    per-obstacle busy flag (holds the gap counter)
//   obst_x_bus/y_bus   packed 12-bit coordinates, obstacle i at [12i+:12]
//   selected[N]        one-hot grant during LAUNCH and RUN
//   done_control       1-cycle launch strobe
//   obstacle_x/y       registered coordinates of granted obstacle, 0 outside RUN
//   active             high in RUN
//   obstacles_cleared  saturating completion count for this round
//   timeout_err        1-cycle pulse after a watchdog expiry
module obstacle_scheduler
  import obstacle_pkg::*;
#(
  parameter int          N_OBST         = N_OBST_DEF,
  parameter int unsigned GAP_CYCLES     = 32000000,
  parameter int unsigned TIMEOUT_CYCLES = 640000000,
  parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
  input  logic                      pclk,
  input  logic                      rst_n,
  input  logic                      game_on,
  input  logic                      menu_on,
  input  logic                      play_selected,
  input  logic [N_OBST-1:0]         obst_done,
  input  logic [N_OBST-1:0]         obst_working,
  input  logic [COORD_W*N_OBST-1:0] obst_x_bus,
  input  logic [COORD_W*N_OBST-1:0] obst_y_bus,
  output logic [N_OBST-1:0]         selected,
  output logic                      done_control,
  output logic [COORD_W-1:0]        obstacle_x,
  output logic [COORD_W-1:0]        obstacle_y,
  output logic                      active,
  output logic [15:0]               obstacles_cleared,
  output logic                      timeout_err
);

  localparam int IDX_W = (N_OBST > 1) ? $clog2(N_OBST) : 1;

  logic [1:0]         state_q, state_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d, idx_next;
  logic [15:0]        clr_q, clr_d;
  logic               to_q, to_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [2:0]         idx3;
  logic               abort;

  assign abort = menu_on | ~play_selected | ~game_on;
  assign idx3  = 3'(idx_q);

`ifdef OBSTACLE_SCHED_RANDOM_ORDER_EN
  logic [7:0]       lfsr_val;
  logic [IDX_W-1:0] cand;
  logic             unused_lfsr;

  obstacle_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (pclk),
    .rst_n (rst_n),
    .en    (1'b1),
    .value (lfsr_val)
  );

  assign cand        = lfsr_val[IDX_W-1:0];
  assign unused_lfsr = ^lfsr_val;
  // Bump a repeated pick to the neighbour so the same obstacle never runs twice in a row.
  assign idx_next    = (cand == idx_q) ? IDX_W'(wrap_inc(3'(cand), N_OBST)) : cand;
`else
  logic unused_seed;
  assign unused_seed = ^LFSR_SEED;
  assign idx_next    = IDX_W'(wrap_inc(idx3, N_OBST));
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    clr_d   = clr_q;
    to_d    = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_GAP;
          cnt_d   = '0;
          clr_d   = '0;
        end
        ST_GAP: begin
          // A still-drawing obstacle freezes the gap so nothing launches over it.
          if (~|obst_working) begin
            if (cnt_q == 32'(GAP_CYCLES - 1)) begin
              state_d = ST_LAUNCH;
              cnt_d   = '0;
              idx_d   = idx_next;
            end else begin
              cnt_d = cnt_q + 32'd1;
            end
          end
        end
        ST_LAUNCH: begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
        ST_RUN: begin
          if (obst_done[idx_q]) begin
            clr_d   = (clr_q == 16'hFFFF) ? clr_q : clr_q + 16'd1;
            state_d = ST_GAP;
            cnt_d   = '0;
          end else if (cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
            to_d    = 1'b1;
            state_d = ST_GAP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Load the coordinate register from the next state so obstacle_x/y is
  // non-zero exactly while the FSM sits in RUN.
  always_comb begin
    x_d = '0;
    y_d = '0;
    if (state_d == ST_RUN) begin
      for (int i = 0; i < N_OBST; i++) begin
        if (idx_d == IDX_W'(i)) begin
          x_d = obst_x_bus[i*COORD_W +: COORD_W];
          y_d = obst_y_bus[i*COORD_W +: COORD_W];
        end
      end
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= IDX_W'(N_OBST - 1);
      clr_q   <= '0;
      to_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      clr_q   <= clr_d;
      to_q    <= to_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign selected          = (state_q == ST_LAUNCH || state_q == ST_RUN) ?
                             N_OBST'(onehot8(idx3)) : '0;
  assign done_control      = (state_q == ST_LAUNCH);
  assign active            = (state_q == ST_RUN);
  assign obstacle_x        = x_q;
  assign obstacle_y        = y_q;
  assign obstacles_cleared = clr_q;
  assign timeout_err       = to_q;

endmodule
